// File: rtl/uart_pkg.sv
// Shared UART package: default FIFO geometry and the DMA request FSM state type.
package uart_pkg;

    localparam int UART_FIFO_DEPTH = 16;
    localparam int UART_DW         = 8;

    // REQ_ON drives txdrdy_n low (request data); REQ_OFF drives it high.
    typedef enum logic {
        REQ_ON  = 1'b0,
        REQ_OFF = 1'b1
    } txdrdy_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Push/pop handshake bundle between the THR writer, the TX FIFO and the transmitter.
interface uart_tx_fifo_if
    import uart_pkg::*;
#(
    parameter int DW = UART_DW
) ();

    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;

    // master: the side that writes bytes and consumes the head byte
    modport master (
        output wr_en, wr_data, tx_ready,
        input  tx_data, tx_valid
    );

    modport slave (
        input  wr_en, wr_data, tx_ready,
        output tx_data, tx_valid
    );

endinterface

// File: rtl/uart_fifo_ram.sv
// DEPTH x DW storage: one synchronous write port, one asynchronous read port.
module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH,
    parameter int DW    = UART_DW,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // NOTE: storage has no reset; the pointers and level define what is valid, so resetting it only costs logic.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit FIFO with FIFO/holding-register modes, sticky overrun flag and
// optional DMA request FSM (enabled by defining UART_TX_FIFO_DMA_EN).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH,
    parameter int DW    = UART_DW,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic            PCLK,
    input  logic            PRESETn,
    uart_tx_fifo_if.slave   bus,
    input  logic            fifo_en,
    input  logic            fifo_clr,
    input  logic            ovr_clr,
    output logic [LW-1:0]   level,
    output logic            empty,
    output logic            full,
    output logic            ovr_err,
    output logic            txdrdy_n
);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic [LW-1:0] capacity;
    logic          fifo_en_q;
    logic          push;
    logic          pop;
    logic          overrun;
    logic          clear;

    // Holding mode behaves as a one-entry FIFO sharing the same storage.
    assign capacity = fifo_en ? LW'(DEPTH) : LW'(1);
    assign full     = (level_q == capacity);
    assign empty    = (level_q == '0);
    assign level    = level_q;

    assign bus.tx_valid = !empty;
    assign pop          = bus.tx_valid && bus.tx_ready;
    assign push         = bus.wr_en && (!full || pop);
    assign overrun      = bus.wr_en && full && !pop;
    // A mode switch flushes the queue exactly like an explicit TX reset.
    assign clear        = fifo_clr || (fifo_en != fifo_en_q);

    uart_fifo_ram #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_ram (
        .clk   (PCLK),
        .we    (push && !clear),
        .waddr (wr_ptr),
        .wdata (bus.wr_data),
        .raddr (rd_ptr),
        .rdata (bus.tx_data)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_q   <= '0;
            ovr_err   <= 1'b0;
            fifo_en_q <= fifo_en;
        end else begin
            fifo_en_q <= fifo_en;
            if (clear) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                level_q <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   level_q <= level_q + 1'b1;
                    2'b01:   level_q <= level_q - 1'b1;
                    default: level_q <= level_q;
                endcase
            end
            // Overrun set wins over a same-cycle clear request.
            if (overrun) begin
                ovr_err <= 1'b1;
            end else if (ovr_clr) begin
                ovr_err <= 1'b0;
            end
        end
    end

`ifdef UART_TX_FIFO_DMA_EN
    txdrdy_state_e state_q;
    txdrdy_state_e state_d;

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q <= REQ_ON;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: next-state gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            REQ_ON:  if (full)  state_d = REQ_OFF;
            REQ_OFF: if (empty) state_d = REQ_ON;
        endcase
    end

    assign txdrdy_n = (state_q == REQ_OFF);
`else
    assign txdrdy_n = 1'b1;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: a reference queue model predicts every
// popped byte and the level/flag/DMA-request outputs after each clock edge.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = UART_FIFO_DEPTH;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          PCLK;
    logic          PRESETn;
    logic          fifo_en;
    logic          fifo_clr;
    logic          ovr_clr;
    logic [LW-1:0] level;
    logic          empty;
    logic          full;
    logic          ovr_err;
    logic          txdrdy_n;

    uart_tx_fifo_if #(.DW(UART_DW)) bus ();

    uart_tx_fifo #(
        .DEPTH (DEPTH),
        .DW    (UART_DW)
    ) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .bus      (bus),
        .fifo_en  (fifo_en),
        .fifo_clr (fifo_clr),
        .ovr_clr  (ovr_clr),
        .level    (level),
        .empty    (empty),
        .full     (full),
        .ovr_err  (ovr_err),
        .txdrdy_n (txdrdy_n)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, mirroring what the DUT should hold after each edge.
    logic [7:0] sb[$];
    int         m_level = 0;
    logic       m_ovr   = 1'b0;
    logic       m_off   = 1'b0;
    logic       m_fen_q = 1'b1;

    function automatic logic exp_txdrdy();
`ifdef UART_TX_FIFO_DMA_EN
        return m_off;
`else
        return 1'b1;
`endif
    endfunction

    // Drive one cycle of stimulus, score any pop, advance the model past the edge.
    task automatic step(input logic wr, input logic [7:0] d, input logic rdy,
                        input logic clr, input logic oclr);
        int   cap;
        logic m_full, m_empty, pop, push, ovr_set;
        cap     = fifo_en ? DEPTH : 1;
        m_full  = (m_level == cap);
        m_empty = (m_level == 0);
        pop     = rdy && !m_empty;
        push    = wr && (!m_full || pop);
        ovr_set = wr && m_full && !pop;

        bus.wr_en   = wr;
        bus.wr_data = d;
        bus.tx_ready = rdy;
        fifo_clr    = clr;
        ovr_clr     = oclr;

        if (pop) begin
            n_checks++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== sb[0]) begin
                n_fail++;
                $display("FAIL pop_data: got valid=%b data=%02h, expected valid=1 data=%02h",
                         bus.tx_valid, bus.tx_data, sb[0]);
            end
        end

        @(posedge PCLK);
        #1;

        if (!PRESETn) begin
            sb.delete();
            m_level = 0;
            m_ovr   = 1'b0;
            m_off   = 1'b0;
        end else begin
            m_off = m_off ? !m_empty : m_full;
            if (clr || (fifo_en != m_fen_q)) begin
                sb.delete();
            end else begin
                if (pop)  void'(sb.pop_front());
                if (push) sb.push_back(d);
            end
            m_level = sb.size();
            if (ovr_set)   m_ovr = 1'b1;
            else if (oclr) m_ovr = 1'b0;
        end
        m_fen_q = fifo_en;

        bus.wr_en    = 1'b0;
        bus.tx_ready = 1'b0;
        fifo_clr     = 1'b0;
        ovr_clr      = 1'b0;
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (level !== '0 || empty !== 1'b1 || full !== 1'b0 || bus.tx_valid !== 1'b0 ||
            ovr_err !== 1'b0 || txdrdy_n !== exp_txdrdy()) begin
            n_fail++;
            $display("FAIL reset_state: got lvl=%0d e=%b f=%b v=%b o=%b dr=%b, expected lvl=0 e=1 f=0 v=0 o=0 dr=%b",
                     level, empty, full, bus.tx_valid, ovr_err, txdrdy_n, exp_txdrdy());
        end
        PRESETn = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_single_push();
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hA5 || level !== LW'(1)) begin
            n_fail++;
            $display("FAIL single_push: got v=%b data=%02h lvl=%0d, expected v=1 data=a5 lvl=1",
                     bus.tx_valid, bus.tx_data, level);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (empty !== 1'b1 || bus.tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drain: got e=%b v=%b, expected e=1 v=0", empty, bus.tx_valid);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_fill_overrun();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (full !== 1'b1 || level !== LW'(DEPTH) || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: got f=%b lvl=%0d e=%b, expected f=1 lvl=%0d e=0",
                     full, level, empty, DEPTH);
        end
        step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (ovr_err !== 1'b1 || level !== LW'(DEPTH) || bus.tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL overrun: got o=%b lvl=%0d head=%02h, expected o=1 lvl=%0d head=00",
                     ovr_err, level, bus.tx_data, DEPTH);
        end
        n_checks++;
        if (txdrdy_n !== exp_txdrdy() || exp_txdrdy() !== 1'b1) begin
            n_fail++;
            $display("FAIL txdrdy_full: got %b, expected 1", txdrdy_n);
        end
        // A fresh overrun in the same cycle as ovr_clr keeps the flag set.
        step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (ovr_err !== m_ovr || m_ovr !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_set_wins: got %b, expected 1", ovr_err);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (ovr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_clear: got %b, expected 0", ovr_err);
        end
    endtask

    task automatic test_push_pop_full();
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (level !== LW'(DEPTH) || full !== 1'b1 || ovr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL push_pop_full: got lvl=%0d f=%b o=%b, expected lvl=%0d f=1 o=0",
                     level, full, ovr_err, DEPTH);
        end
    endtask

    task automatic test_drain_wrap();
        while (m_level > 0) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (txdrdy_n !== exp_txdrdy() || level !== LW'(m_level)) begin
                n_fail++;
                $display("FAIL drain_status: got dr=%b lvl=%0d, expected dr=%b lvl=%0d",
                         txdrdy_n, level, exp_txdrdy(), m_level);
            end
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (empty !== 1'b1 || txdrdy_n !== exp_txdrdy()) begin
            n_fail++;
            $display("FAIL drain_empty: got e=%b dr=%b, expected e=1 dr=%b",
                     empty, txdrdy_n, exp_txdrdy());
        end
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'(8'h80 + i), ((i % 4) != 0), 1'b0, 1'b0);
        end
        while (m_level > 0) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (empty !== 1'b1 || level !== '0) begin
            n_fail++;
            $display("FAIL wrap_drain: got e=%b lvl=%0d, expected e=1 lvl=0", empty, level);
        end
    endtask

    task automatic test_holding_mode();
        fifo_en = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (full !== 1'b1 || level !== LW'(1) || bus.tx_data !== 8'h11) begin
            n_fail++;
            $display("FAIL hold_full: got f=%b lvl=%0d data=%02h, expected f=1 lvl=1 data=11",
                     full, level, bus.tx_data);
        end
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (ovr_err !== 1'b1 || level !== LW'(1) || bus.tx_data !== 8'h11) begin
            n_fail++;
            $display("FAIL hold_overrun: got o=%b lvl=%0d data=%02h, expected o=1 lvl=1 data=11",
                     ovr_err, level, bus.tx_data);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (empty !== 1'b1 || ovr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_drain: got e=%b o=%b, expected e=1 o=0", empty, ovr_err);
        end
        fifo_en = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_clear_and_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (level !== LW'(5)) begin
            n_fail++;
            $display("FAIL pre_clear_level: got %0d, expected 5", level);
        end
        step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (level !== '0 || empty !== 1'b1 || bus.tx_valid !== 1'b0 || ovr_err !== m_ovr) begin
            n_fail++;
            $display("FAIL fifo_clr: got lvl=%0d e=%b v=%b o=%b, expected lvl=0 e=1 v=0 o=%b",
                     level, empty, bus.tx_valid, ovr_err, m_ovr);
        end
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (level !== LW'(9)) begin
            n_fail++;
            $display("FAIL pre_reset_level: got %0d, expected 9", level);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        PRESETn = 1'b0;
        step(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (level !== '0 || empty !== 1'b1 || full !== 1'b0 || bus.tx_valid !== 1'b0 ||
            ovr_err !== 1'b0 || txdrdy_n !== exp_txdrdy()) begin
            n_fail++;
            $display("FAIL midop_reset: got lvl=%0d e=%b f=%b v=%b o=%b dr=%b, expected lvl=0 e=1 f=0 v=0 o=0 dr=%b",
                     level, empty, full, bus.tx_valid, ovr_err, txdrdy_n, exp_txdrdy());
        end
        PRESETn = 1'b1;
        step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (level !== LW'(1) || bus.tx_data !== 8'h5A) begin
            n_fail++;
            $display("FAIL post_reset_push: got lvl=%0d data=%02h, expected lvl=1 data=5a",
                     level, bus.tx_data);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        PRESETn      = 1'b0;
        fifo_en      = 1'b1;
        fifo_clr     = 1'b0;
        ovr_clr      = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_data  = 8'h00;
        bus.tx_ready = 1'b0;

        test_reset();
        test_single_push();
        test_fill_overrun();
        test_push_pop_full();
        test_drain_wrap();
        test_holding_mode();
        test_clear_and_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
